zeroriscy_ds_sram: RTL and testbench
====================================

// Module: zeroriscy_ds_sram
// PURPOSE
//  Responder (slave) end of the zero-riscy req/gnt/rvalid bus. It sits on the crossbar's
//  ds_* data-slave port and serves the 0x801x_xxxx data region from an internal word
//  array. Wait states are programmable so the crossbar's gnt/rvalid paths can be
//  exercised with non-zero latency. One transaction is outstanding at a time; a new grant
//  may overlap the previous response beat.
// PARAMETERS
//  AW     default 10            word-address bits; depth = 2**AW 32-bit words (4 KiB)
//  BASE   default 32'h8010_0000 region base; region = BASE .. BASE + 4*2**AW - 1
//  WAIT   default 0             extra cycles between grant and rvalid (0..15)
// PORTS
//  clk     in   1   clock, all state on rising edge
//  reset   in   1   synchronous, active-high reset
//  req     in   1   request valid; held with fields stable until gnt
//  we      in   1   1 = write, 0 = read
//  be      in   4   byte enables for writes; be[i] covers wdata[8i+7:8i]
//  addr    in   32  byte address; addr[1:0] ignored
//  wdata   in   32  write data
//  rdata   out  32  read data; valid only while rvalid
//  gnt     out  1   request accepted this cycle (combinational from req and state)
//  rvalid  out  1   one-cycle response strobe, exactly one per grant
//  err     out  1   error flag, qualified by rvalid
// BEHAVIOUR
//  - Reset: state IDLE, wait counter 0, rvalid = 0, err = 0, rdata = 0, and the pending
//    latch is cleared. Array contents are NOT cleared. An in-flight transaction is dropped
//    and gets no rvalid.
//  - gnt = req & (state==IDLE | state==RESP). gnt is never asserted while reset is high.
//  - Grant: latch we, be, wdata, word index addr[AW+1:2], and the range-miss flag.
//    - Miss when addr[31:2] is outside BASE[31:2] .. BASE[31:2] + 2**AW - 1.
//    - Next state: WAIT==0 -> RESP; otherwise BUSY with the counter loaded with WAIT-1.
//  - BUSY: counter decrements once per cycle. When it reaches 0, the next state is RESP,
//    so rvalid arrives exactly WAIT+1 cycles after the gnt cycle.
//  - RESP: rvalid = 1 for exactly one cycle.
//    - Hit read: rdata = mem[idx], err = 0.
//    - Hit write: rdata = 0, err = 0.
//    - Miss: rdata = 0, err = 1, and the array is not modified.
//  - RESP exit: if gnt fires in the RESP cycle, load the new request (back-to-back,
//    1 transaction/cycle throughput at WAIT=0). Otherwise return to IDLE.
//  - Write commit: the array is written on the clock edge that ends the RESP cycle, per
//    enabled byte only; be==4'h0 leaves memory unchanged.
//    - A read granted in that same RESP cycle responds in a later cycle and therefore sees
//      the new data (read-after-write coherent).
//  - rdata and err are 0 whenever rvalid = 0.
//  - Counter is 4 bits. WAIT > 15 is illegal, and an elaboration-time check must fail.
//  - Out-of-protocol req drop before gnt is tolerated: nothing is latched without gnt.
// TESTING
//  1. WAIT=0: write 0xDEADBEEF to 0x8010_0010 with be=F, then read it -> each gnt in the
//     req cycle, rvalid next cycle, read rdata=0xDEADBEEF, err=0.
//  2. Byte enables: preload 0x11223344, write 0xAABBCCDD with be=4'b0101 -> readback
//     0x11BB33DD. Write with be=0 -> no change.
//  3. WAIT=3: a read granted at cycle t gives rvalid at t+4 only. A req raised at t+1..t+3
//     sees gnt=0, and is granted at t+4 together with the rvalid.
//  4. Back-to-back, WAIT=0: req held high for 4 reads of consecutive words -> 4 gnts and
//     4 rvalids on consecutive cycles, with the data in order.
//  5. Range error: write to 0x8010_1000 (AW=10) and read 0x8000_0000 -> rvalid with err=1
//     and rdata=0. The word at BASE is untouched.
//  6. Reset mid-op: WAIT=5, grant a write, assert reset 2 cycles later -> no rvalid
//     appears and the memory is unchanged. The first req after reset deasserts gets gnt.

Source files
------------

// File: rtl/zeroriscy_ds_sram.sv
// Data-slave SRAM responder for the zero-riscy req/gnt/rvalid bus.
// One transaction in flight, programmable wait states, per-byte write commit at response time.
module zeroriscy_ds_sram #(
    parameter int unsigned AW   = 10,
    parameter logic [31:0] BASE = 32'h8010_0000,
    parameter int unsigned WAIT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [3:0]  be,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        gnt,
    output logic        rvalid,
    output logic        err
);

    if (WAIT > 15) begin : gen_wait_check
        $error("WAIT must be in the range 0..15");
    end

    localparam int unsigned Depth    = 2 ** AW;
    localparam logic [3:0]  WaitLoad = (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [3:0]      be_q, be_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic            miss_q, miss_d;
    logic [31:0]     mem_q [Depth];

    logic [29:0]     word_off;
    logic            addr_miss;
    logic            unused_addr_lsb;

    assign unused_addr_lsb = ^addr[1:0];

    // Unsigned offset from the base word: anything below BASE wraps to a large value.
    always_comb begin
        word_off  = addr[31:2] - BASE[31:2];
        addr_miss = (word_off >> AW) != '0;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        idx_d   = idx_q;
        miss_d  = miss_q;
        gnt     = req & ~reset & ((state_q == StIdle) | (state_q == StResp));

        case (state_q)
            StBusy: begin
                if (cnt_q == 4'd0) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp:  state_d = StIdle;
            default: ;
        endcase

        if (gnt) begin
            we_d    = we;
            be_d    = be;
            wdata_d = wdata;
            idx_d   = addr[AW+1:2];
            miss_d  = addr_miss;
            if (WAIT == 0) begin
                state_d = StResp;
            end else begin
                state_d = StBusy;
                cnt_d   = WaitLoad;
            end
        end
    end

    always_comb begin
        rvalid = (state_q == StResp);
        err    = rvalid & miss_q;
        rdata  = (rvalid & ~we_q & ~miss_q) ? mem_q[idx_q] : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            be_q    <= 4'h0;
            wdata_q <= 32'h0;
            idx_q   <= '0;
            miss_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            idx_q   <= idx_d;
            miss_q  <= miss_d;
        end
    end

    // Commit lands on the edge closing the response, so a read granted alongside sees it.
    always_ff @(posedge clk) begin
        if (!reset && (state_q == StResp) && we_q && !miss_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem_q[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_zeroriscy_ds_sram.sv
// Self-checking bench: three responders (WAIT = 0, 3, 5) checked against a word-map model.
module tb_zeroriscy_ds_sram;

    localparam logic [31:0] BASE = 32'h8010_0000;
    localparam logic [31:0] SIZE = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        req_v    [3];
    logic        gnt_v    [3];
    logic        rvalid_v [3];
    logic        err_v    [3];
    logic [31:0] rdata_v  [3];

    int          wait_of  [3] = '{0, 3, 5};
    logic [31:0] mdl [bit [31:0]];
    int          n_pass = 0;
    int          n_total = 0;

    always #5 clk = ~clk;

    zeroriscy_ds_sram #(.AW(10), .BASE(BASE), .WAIT(0)) u_dut0 (
        .clk(clk), .reset(reset), .req(req_v[0]), .we(we), .be(be), .addr(addr),
        .wdata(wdata), .rdata(rdata_v[0]), .gnt(gnt_v[0]), .rvalid(rvalid_v[0]), .err(err_v[0])
    );
    zeroriscy_ds_sram #(.AW(10), .BASE(BASE), .WAIT(3)) u_dut3 (
        .clk(clk), .reset(reset), .req(req_v[1]), .we(we), .be(be), .addr(addr),
        .wdata(wdata), .rdata(rdata_v[1]), .gnt(gnt_v[1]), .rvalid(rvalid_v[1]), .err(err_v[1])
    );
    zeroriscy_ds_sram #(.AW(10), .BASE(BASE), .WAIT(5)) u_dut5 (
        .clk(clk), .reset(reset), .req(req_v[2]), .we(we), .be(be), .addr(addr),
        .wdata(wdata), .rdata(rdata_v[2]), .gnt(gnt_v[2]), .rvalid(rvalid_v[2]), .err(err_v[2])
    );

    function automatic bit in_region(logic [31:0] a);
        return (a >= BASE) && (a < BASE + SIZE);
    endfunction

    function automatic bit [31:0] key(int d, logic [31:0] a);
        return {d[1:0], a[31:2]};
    endfunction

    function automatic logic [31:0] exp_read(int d, logic [31:0] a);
        if (!in_region(a)) return 32'h0;
        if (!mdl.exists(key(d, a))) return 32'hxxxx_xxxx;
        return mdl[key(d, a)];
    endfunction

    task automatic mdl_write(int d, logic [3:0] b, logic [31:0] a, logic [31:0] wd);
        logic [31:0] w;
        if (!in_region(a)) return;
        w = mdl.exists(key(d, a)) ? mdl[key(d, a)] : 32'h0;
        for (int i = 0; i < 4; i++) if (b[i]) w[8*i +: 8] = wd[8*i +: 8];
        mdl[key(d, a)] = w;
    endtask

    // One complete transaction; gwait = cycles spent waiting for gnt, lat = cycles gnt->rvalid.
    task automatic do_txn(input int d, input logic w, input logic [3:0] b, input logic [31:0] a,
                          input logic [31:0] wd, output int gwait, output int lat,
                          output logic [31:0] rd, output logic e);
        @(negedge clk);
        we = w; be = b; addr = a; wdata = wd; req_v[d] = 1'b1;
        gwait = 0; lat = -1; rd = 32'h0; e = 1'b0;
        #1;
        while (!gnt_v[d] && gwait < 40) begin
            @(negedge clk); #1; gwait++;
        end
        if (!gnt_v[d]) begin
            req_v[d] = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        req_v[d] = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            #1;
            if (rvalid_v[d]) begin
                lat = c; rd = rdata_v[d]; e = err_v[d];
                break;
            end
            @(negedge clk);
        end
        if (w && lat > 0) mdl_write(d, b, a, wd);
    endtask

    task automatic test_reset();
        reset = 1'b1; we = 1'b0; be = 4'h0; addr = 32'h0; wdata = 32'h0;
        for (int d = 0; d < 3; d++) req_v[d] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            n_total++;
            if (rvalid_v[d] !== 1'b0 || err_v[d] !== 1'b0 || rdata_v[d] !== 32'h0) begin
                $display("FAIL reset_outputs dut%0d: rvalid=%b err=%b rdata=%h, required 0/0/0",
                         d, rvalid_v[d], err_v[d], rdata_v[d]);
            end else n_pass++;
            req_v[d] = 1'b1;
        end
        #1;
        for (int d = 0; d < 3; d++) begin
            n_total++;
            if (gnt_v[d] !== 1'b0) $display("FAIL gnt_in_reset dut%0d: gnt=%b, required 0", d, gnt_v[d]);
            else n_pass++;
        end
        @(negedge clk);
        for (int d = 0; d < 3; d++) req_v[d] = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int g, l; logic [31:0] rd; logic e;
        do_txn(0, 1'b1, 4'hF, 32'h8010_0010, 32'hDEAD_BEEF, g, l, rd, e);
        n_total++;
        if (g !== 0 || l !== 1 || e !== 1'b0 || rd !== 32'h0)
            $display("FAIL basic_write: gwait=%0d lat=%0d err=%b rdata=%h, required 0/1/0/0", g, l, e, rd);
        else n_pass++;
        do_txn(0, 1'b0, 4'hF, 32'h8010_0010, 32'h0, g, l, rd, e);
        n_total++;
        if (g !== 0 || l !== 1 || e !== 1'b0 || rd !== 32'hDEAD_BEEF)
            $display("FAIL basic_read: gwait=%0d lat=%0d err=%b rdata=%h, required 0/1/0/deadbeef", g, l, e, rd);
        else n_pass++;
    endtask

    task automatic test_byte_en();
        int g, l; logic [31:0] rd; logic e;
        do_txn(0, 1'b1, 4'hF, 32'h8010_0020, 32'h1122_3344, g, l, rd, e);
        do_txn(0, 1'b1, 4'b0101, 32'h8010_0020, 32'hAABB_CCDD, g, l, rd, e);
        do_txn(0, 1'b0, 4'hF, 32'h8010_0020, 32'h0, g, l, rd, e);
        n_total++;
        if (rd !== 32'h11BB_33DD) $display("FAIL byte_en_0101: rdata=%h, required 11bb33dd", rd);
        else n_pass++;
        do_txn(0, 1'b1, 4'h0, 32'h8010_0020, 32'hFFFF_FFFF, g, l, rd, e);
        do_txn(0, 1'b0, 4'hF, 32'h8010_0020, 32'h0, g, l, rd, e);
        n_total++;
        if (rd !== 32'h11BB_33DD) $display("FAIL byte_en_zero: rdata=%h, required 11bb33dd", rd);
        else n_pass++;
    endtask

    task automatic test_wait3();
        int g, l; logic [31:0] rd; logic e;
        do_txn(1, 1'b1, 4'hF, 32'h8010_0040, 32'h1234_5678, g, l, rd, e);
        n_total++;
        if (l !== 4) $display("FAIL wait3_write_latency: lat=%0d, required 4", l);
        else n_pass++;
        @(negedge clk);
        we = 1'b0; addr = 32'h8010_0040; req_v[1] = 1'b1;
        #1;
        n_total++;
        if (gnt_v[1] !== 1'b1) $display("FAIL wait3_first_gnt: gnt=%b, required 1", gnt_v[1]);
        else n_pass++;
        @(posedge clk);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk); #1;
            n_total++;
            if (gnt_v[1] !== 1'b0 || rvalid_v[1] !== 1'b0)
                $display("FAIL wait3_busy_t+%0d: gnt=%b rvalid=%b, required 0/0", k, gnt_v[1], rvalid_v[1]);
            else n_pass++;
        end
        @(negedge clk); #1;
        n_total++;
        if (rvalid_v[1] !== 1'b1 || rdata_v[1] !== 32'h1234_5678 || gnt_v[1] !== 1'b1)
            $display("FAIL wait3_resp_t+4: rvalid=%b rdata=%h gnt=%b, required 1/12345678/1",
                     rvalid_v[1], rdata_v[1], gnt_v[1]);
        else n_pass++;
        @(posedge clk);
        @(negedge clk);
        req_v[1] = 1'b0;
        l = 1; #1;
        while (!rvalid_v[1] && l < 20) begin
            @(negedge clk); #1; l++;
        end
        n_total++;
        if (l !== 4 || rdata_v[1] !== 32'h1234_5678)
            $display("FAIL wait3_second_read: lat=%0d rdata=%h, required 4/12345678", l, rdata_v[1]);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int g, l; logic [31:0] rd; logic e;
        for (int k = 0; k < 4; k++)
            do_txn(0, 1'b1, 4'hF, 32'h8010_0100 + 32'(4 * k), $urandom, g, l, rd, e);
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            if (k < 4) begin
                we = 1'b0; addr = 32'h8010_0100 + 32'(4 * k); req_v[0] = 1'b1;
            end else req_v[0] = 1'b0;
            #1;
            if (k < 4) begin
                n_total++;
                if (gnt_v[0] !== 1'b1) $display("FAIL b2b_gnt_%0d: gnt=%b, required 1", k, gnt_v[0]);
                else n_pass++;
            end
            if (k > 0) begin
                n_total++;
                if (rvalid_v[0] !== 1'b1 || rdata_v[0] !== exp_read(0, 32'h8010_0100 + 32'(4 * (k - 1))))
                    $display("FAIL b2b_resp_%0d: rvalid=%b rdata=%h, required 1/%h", k - 1, rvalid_v[0],
                             rdata_v[0], exp_read(0, 32'h8010_0100 + 32'(4 * (k - 1))));
                else n_pass++;
            end
            @(posedge clk);
        end
    endtask

    task automatic test_range_err();
        int g, l; logic [31:0] rd; logic e;
        do_txn(0, 1'b1, 4'hF, BASE, 32'hC0FF_EE00, g, l, rd, e);
        do_txn(0, 1'b1, 4'hF, 32'h8010_1000, 32'h5555_AAAA, g, l, rd, e);
        n_total++;
        if (l !== 1 || e !== 1'b1 || rd !== 32'h0)
            $display("FAIL range_write: lat=%0d err=%b rdata=%h, required 1/1/0", l, e, rd);
        else n_pass++;
        do_txn(0, 1'b0, 4'hF, 32'h8000_0000, 32'h0, g, l, rd, e);
        n_total++;
        if (l !== 1 || e !== 1'b1 || rd !== 32'h0)
            $display("FAIL range_read: lat=%0d err=%b rdata=%h, required 1/1/0", l, e, rd);
        else n_pass++;
        do_txn(0, 1'b0, 4'hF, BASE, 32'h0, g, l, rd, e);
        n_total++;
        if (e !== 1'b0 || rd !== 32'hC0FF_EE00)
            $display("FAIL range_base_intact: err=%b rdata=%h, required 0/c0ffee00", e, rd);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int g, l, nrv, first; logic [31:0] rd; logic e;
        do_txn(2, 1'b1, 4'hF, 32'h8010_0080, 32'hA5A5_0F0F, g, l, rd, e);
        n_total++;
        if (l !== 6) $display("FAIL wait5_latency: lat=%0d, required 6", l);
        else n_pass++;
        @(negedge clk);
        we = 1'b1; be = 4'hF; addr = 32'h8010_0080; wdata = 32'h5A5A_F0F0; req_v[2] = 1'b1;
        #1;
        n_total++;
        if (gnt_v[2] !== 1'b1) $display("FAIL midreset_grant: gnt=%b, required 1", gnt_v[2]);
        else n_pass++;
        @(posedge clk);
        @(negedge clk);
        req_v[2] = 1'b0;
        @(negedge clk);
        reset = 1'b1; we = 1'b0; req_v[2] = 1'b1;
        #1;
        n_total++;
        if (gnt_v[2] !== 1'b0) $display("FAIL midreset_gnt_in_reset: gnt=%b, required 0", gnt_v[2]);
        else n_pass++;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_total++;
        if (gnt_v[2] !== 1'b1) $display("FAIL midreset_first_gnt: gnt=%b, required 1", gnt_v[2]);
        else n_pass++;
        @(posedge clk);
        @(negedge clk);
        req_v[2] = 1'b0;
        nrv = 0; first = -1; rd = 32'h0;
        for (int c = 1; c <= 12; c++) begin
            #1;
            if (rvalid_v[2]) begin
                nrv++;
                if (first < 0) begin
                    first = c; rd = rdata_v[2];
                end
            end
            @(negedge clk);
        end
        n_total++;
        if (nrv !== 1 || first !== 6 || rd !== 32'hA5A5_0F0F)
            $display("FAIL midreset_dropped: rvalids=%0d first=%0d rdata=%h, required 1/6/a5a50f0f",
                     nrv, first, rd);
        else n_pass++;
    endtask

    task automatic test_random();
        int g, l, d; logic [31:0] a, wd, rd, exp_rd; logic e, w; logic [3:0] b;
        for (int dd = 0; dd < 3; dd++)
            for (int k = 0; k < 16; k++)
                do_txn(dd, 1'b1, 4'hF, BASE + 32'h200 + 32'(4 * k), $urandom, g, l, rd, e);
        for (int n = 0; n < 60; n++) begin
            d  = int'($urandom_range(0, 2));
            w  = 1'($urandom);
            b  = 4'($urandom);
            wd = $urandom;
            case ($urandom_range(0, 7))
                0:       a = BASE - 32'(4 * $urandom_range(1, 64));
                1:       a = BASE + SIZE + 32'(4 * $urandom_range(0, 64));
                default: a = BASE + 32'h200 + 32'(4 * $urandom_range(0, 15));
            endcase
            a = a | 32'($urandom_range(0, 3));
            exp_rd = w ? 32'h0 : exp_read(d, a);
            do_txn(d, w, b, a, wd, g, l, rd, e);
            n_total++;
            if (g !== 0 || l !== wait_of[d] + 1 || e !== !in_region(a) || rd !== exp_rd)
                $display("FAIL random_%0d dut%0d we=%b addr=%h: gwait=%0d lat=%0d err=%b rdata=%h, required 0/%0d/%b/%h",
                         n, d, w, a, g, l, e, rd, wait_of[d] + 1, !in_region(a), exp_rd);
            else n_pass++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_byte_en();
        test_wait3();
        test_back_to_back();
        test_range_err();
        test_reset_mid();
        test_random();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
